led_pattern_ctrl: RTL and testbench

Parametrised multi-LED pattern generator: a programmable prescaler drives one of four display modes (off, binary count, bouncing chase, PWM breathe) onto `NUM_LEDS` board LEDs. It replaces fixed-rate divider-plus-counter blinkers in board bring-up designs. It takes the board clock directly and produces glitch-free registered LED drives plus a step strobe for other logic.

---
 rtl/led_pattern_ctrl.sv | 147 ++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// led_pattern_ctrl : prescaled multi-LED pattern generator (off/count/chase/breathe)
// Rev 1.0
// ============================================================================
module led_pattern_ctrl #(
  parameter int NUM_LEDS = 3,
  parameter int PRE_W    = 24,
  parameter int PWM_W    = 6
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [3:0]          speed,
  output logic [NUM_LEDS-1:0] led,
  output logic                step
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_COUNT   = 2'b01,
    MODE_CHASE   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  localparam logic                DIR_UP   = 1'b0;
  localparam logic                DIR_DN   = 1'b1;
  localparam logic [NUM_LEDS-1:0] POS_RST  = NUM_LEDS'(1);
  localparam logic [PWM_W-1:0]    DUTY_MAX = '1;

  logic [PRE_W-1:0]    pre_q, pre_d, pre_mask;
  logic [PWM_W-1:0]    pwm_q, pwm_d;
  logic [PWM_W-1:0]    duty_q, duty_d;
  logic [NUM_LEDS-1:0] cnt_q, cnt_d;
  logic [NUM_LEDS-1:0] pos_q, pos_d;
  logic [NUM_LEDS-1:0] led_q, led_d, disp;
  logic                cdir_q, cdir_d;
  logic                bdir_q, bdir_d;
  logic                step_q, step_d;
  logic                tick;
  mode_e               mode_q, mode_d;
  int                  spd;

  assign led  = led_q;
  assign step = step_q;

  // Tick when the low (PRE_W - s) prescaler bits are all ones, giving a
  // period of 2^(PRE_W - s) without restarting on a speed change.
  always_comb begin
    spd = int'(speed);
    if (spd > PRE_W - 1) spd = PRE_W - 1;
    pre_mask = {PRE_W{1'b1}} >> spd;
    tick     = en && ((pre_q & pre_mask) == pre_mask);
  end

  always_comb begin
    disp = '0;
    case (mode_q)
      MODE_COUNT:   disp = cnt_q;
      MODE_CHASE:   disp = pos_q;
      MODE_BREATHE: disp = {NUM_LEDS{pwm_q < duty_q}};
      default:      disp = '0;
    endcase
    led_d = en ? disp : '0;
  end

  always_comb begin
    pre_d  = pre_q;
    pwm_d  = pwm_q;
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    cdir_d = cdir_q;
    duty_d = duty_q;
    bdir_d = bdir_q;
    mode_d = mode_q;
    step_d = 1'b0;

    // A mode change restarts everything and wins over a coincident tick.
    if (mode != mode_q) begin
      pre_d  = '0;
      pwm_d  = '0;
      cnt_d  = '0;
      pos_d  = POS_RST;
      cdir_d = DIR_UP;
      duty_d = '0;
      bdir_d = DIR_UP;
      mode_d = mode_e'(mode);
    end else if (en) begin
      pre_d  = pre_q + PRE_W'(1);
      pwm_d  = pwm_q + PWM_W'(1);
      step_d = tick;
      if (tick) begin
        case (mode_q)
          MODE_COUNT: cnt_d = cnt_q + NUM_LEDS'(1);
          MODE_CHASE: begin
            if (cdir_q == DIR_UP) begin
              pos_d = pos_q << 1;
              if (pos_q[NUM_LEDS-2]) cdir_d = DIR_DN;
            end else begin
              pos_d = pos_q >> 1;
              if (pos_q[1]) cdir_d = DIR_UP;
            end
          end
          MODE_BREATHE: begin
            if (bdir_q == DIR_UP) begin
              duty_d = duty_q + PWM_W'(1);
              if (duty_d == DUTY_MAX) bdir_d = DIR_DN;
            end else begin
              duty_d = duty_q - PWM_W'(1);
              if (duty_d == '0) bdir_d = DIR_UP;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre_q  <= '0;
      pwm_q  <= '0;
      cnt_q  <= '0;
      pos_q  <= POS_RST;
      cdir_q <= DIR_UP;
      duty_q <= '0;
      bdir_q <= DIR_UP;
      mode_q <= MODE_OFF;
      led_q  <= '0;
      step_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      pwm_q  <= pwm_d;
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      cdir_q <= cdir_d;
      duty_q <= duty_d;
      bdir_q <= bdir_d;
      mode_q <= mode_d;
      led_q  <= led_d;
      step_q <= step_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// tb_led_pattern_ctrl : directed + randomized check against a step-count model
// Rev 1.0
// ============================================================================
module tb_led_pattern_ctrl;

  localparam int N     = 3;
  localparam int PRE_W = 4;
  localparam int PWM_W = 3;

  logic         clk   = 1'b0;
  logic         rstn  = 1'b0;
  logic         en    = 1'b0;
  logic [1:0]   mode  = 2'b00;
  logic [3:0]   speed = 4'd2;
  logic [N-1:0] led;
  logic         step;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: enabled cycles and pattern steps since the last restart.
  int         m_c = 0;
  int         m_k = 0;
  logic [1:0] m_mode = 2'b00;
  int         exp_led = 0;
  int         exp_step = 0;

  int chase_exp[5] = '{2, 4, 2, 1, 2};

  led_pattern_ctrl #(
    .NUM_LEDS (N),
    .PRE_W    (PRE_W),
    .PWM_W    (PWM_W)
  ) u_dut (
    .clk   (clk),
    .rstn  (rstn),
    .en    (en),
    .mode  (mode),
    .speed (speed),
    .led   (led),
    .step  (step)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  // Triangle wave 0..m..0 with period 2m.
  function automatic int tri_wave(input int k, input int m);
    int r;
    r = k % (2 * m);
    return (r <= m) ? r : 2 * m - r;
  endfunction

  function automatic int period(input logic [3:0] sp);
    int s;
    s = (int'(sp) > PRE_W - 1) ? PRE_W - 1 : int'(sp);
    return 1 << (PRE_W - s);
  endfunction

  function automatic int disp(input logic [1:0] md, input int k, input int c);
    int duty;
    duty = tri_wave(k, (1 << PWM_W) - 1);
    case (md)
      2'b01:   return k % (1 << N);
      2'b10:   return 1 << tri_wave(k, N - 1);
      2'b11:   return ((c % (1 << PWM_W)) < duty) ? (1 << N) - 1 : 0;
      default: return 0;
    endcase
  endfunction

  // Predicts the outputs the coming clock edge will register.
  task automatic model_advance();
    int p;
    p = period(speed);
    if (!rstn) begin
      m_c = 0; m_k = 0; m_mode = 2'b00; exp_led = 0; exp_step = 0;
    end else if (mode != m_mode) begin
      exp_led  = en ? disp(m_mode, m_k, m_c) : 0;
      exp_step = 0;
      m_c = 0; m_k = 0; m_mode = mode;
    end else if (en) begin
      exp_led  = disp(m_mode, m_k, m_c);
      exp_step = ((m_c % p) == p - 1) ? 1 : 0;
      m_c++;
      if (exp_step == 1 && m_mode != 2'b00) m_k++;
    end else begin
      exp_led = 0; exp_step = 0;
    end
  endtask

  task automatic cycle();
    model_advance();
    @(posedge clk);
    #1;
    check("led", led, exp_led);
    check("step", step, exp_step);
  endtask

  task automatic wait_step(output int gap);
    gap = 0;
    do begin
      cycle();
      gap++;
    end while (step !== 1'b1 && gap < 64);
    if (step !== 1'b1) check("step_timeout", step, 1);
  endtask

  initial begin
    int gap;
    int lit;
    rstn = 1'b0; en = 1'b1; mode = 2'b01; speed = 4'd2;
    repeat (3) cycle();
    check("rst_led", led, 0);
    check("rst_step", step, 0);
    rstn = 1'b1;

    // COUNT: 001..111 then wrap to 000
    for (int i = 0; i < 8; i++) begin
      wait_step(gap);
      if (i > 0) check("count_gap", gap + 1, 4);
      cycle();
      check("count_led", led, (i + 1) % 8);
    end

    // en toggle at 011
    for (int i = 0; i < 3; i++) begin
      wait_step(gap);
      cycle();
    end
    check("pre_en_led", led, 3);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("en_off_led", led, 0);
      check("en_off_step", step, 0);
    end
    en = 1'b1;
    cycle();
    check("en_resume_led", led, 3);
    wait_step(gap);
    cycle();
    check("en_next_led", led, 4);

    // Mode change COUNT -> CHASE at cnt = 5, mid-period
    wait_step(gap);
    cycle();
    check("cnt5_led", led, 5);
    mode = 2'b10;
    cycle();
    cycle();
    check("chg_led", led, 1);
    for (int i = 0; i < 5; i++) begin
      wait_step(gap);
      check("chase_gap", (i == 0) ? gap + 1 : gap + 1, 4);
      cycle();
      check("chase_led", led, chase_exp[i]);
    end

    // speed clamp
    speed = 4'd15;
    wait_step(gap);
    wait_step(gap);
    check("clamp_gap", gap, 2);
    speed = 4'd2;

    // BREATHE
    mode = 2'b11;
    cycle();
    cycle();
    check("breathe_first_led", led, 0);
    for (int i = 0; i < 4; i++) wait_step(gap);
    speed = 4'd0;
    lit = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (led == 3'b111) lit++;
    end
    check("breathe_lit", lit, 4);
    speed = 4'd2;
    repeat (30) cycle();

    // Async reset between edges
    #2;
    rstn = 1'b0;
    #1;
    check("async_led", led, 0);
    check("async_step", step, 0);
    cycle();
    rstn = 1'b1;
    repeat (40) cycle();

    // Randomized phase
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(7) != 0);
      if ($urandom_range(49) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(39) == 0) speed = 4'($urandom_range(15));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
